alu_in_mc_frontend: RTL
=======================

Name: alu_in_mc_frontend

Overview:
Multi-channel successor to the single alu_in bus responder. It accepts NUM_CH independent valid/ready alu_in request channels and arbitrates between them round-robin. The accepted operation is evaluated and the result is queued, tagged with its channel ID, in a DEPTH-entry FIFO. A single valid/ready result port drains the FIFO toward the scoreboard/datapath side of the ALU environment.

Parameters:
NUM_CH, 4, number of request channels (2..16)
ALU_IN_OP_WIDTH, 8, width of operands a/b
DEPTH, 8, result FIFO entries (power of 2, >=2)
CH_W, $clog2(NUM_CH), channel tag width (derived)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset; asynchronous assert, active-low
alu_rst  input  1  synchronous soft flush, active-high
in_valid  input  NUM_CH  per-channel request valid
in_ready  output  NUM_CH  per-channel accept (one-hot or zero)
in_op  input  3*NUM_CH  per-channel opcode, channel i at [3i+2:3i]
in_a  input  ALU_IN_OP_WIDTH*NUM_CH  per-channel operand a
in_b  input  ALU_IN_OP_WIDTH*NUM_CH  per-channel operand b
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_ch  output  CH_W  originating channel
out_op  output  3  originating opcode
out_result  output  2*ALU_IN_OP_WIDTH  result
drop_cnt  output  8  count of dropped requests

Behaviour:
- Reset (rst low, async): FIFO count=0, out_valid=0, out_ch/out_op/out_result=0, rr_ptr=0, drop_cnt=0. in_ready=0 while rst is low.
- Opcodes:
  - 0 no_op: accepted, not enqueued.
  - 1 add: zero-extended a+b, 2W bits, carry kept.
  - 2 and and 3 xor: zero-extended to 2W.
  - 4 mul: full unsigned 2W product.
  - 5..7 reserved: accepted, not enqueued, drop_cnt+1.
  - drop_cnt saturates at 255.
- Space condition: space = (count<DEPTH) OR (out_valid AND out_ready).
- Arbitration:
  - If space and alu_rst=0, grant the first i with in_valid[i]=1, searching from rr_ptr upward with wrap.
  - in_ready[grant]=1; all other in_ready bits are 0.
  - in_ready is combinational from in_valid, rr_ptr and FIFO state. Masters must not make in_valid depend on in_ready.
  - Transfer occurs when in_valid[i] and in_ready[i] are both 1.
  - On transfer from i (including no_op/reserved): rr_ptr <= (i+1) mod NUM_CH. With no transfer, rr_ptr holds.
- Enqueue: the result is computed combinationally from the granted channel and written to the FIFO at the transfer edge.
  - Latency: transfer at edge t with an empty FIFO gives out_valid=1 from after edge t (1 cycle).
- Output:
  - out_* shows the FIFO head.
  - out_valid=1 iff count>0.
  - Head is stable while out_valid=1 and out_ready=0.
  - Pop on out_valid and out_ready.
  - Simultaneous push and pop at full is allowed; count is unchanged.
  - Ordering is strict FIFO across channels.
- Pointers: write/read pointers wrap mod DEPTH. count ranges 0..DEPTH; count>DEPTH is an error and must never occur.
- alu_rst=1 at an edge:
  - count, pointers and rr_ptr go to 0; out_valid=0 next cycle.
  - in_ready=0 during that cycle, so no transfer occurs.
  - drop_cnt is retained.
  - A pop presented in the same cycle is discarded by the flush.
- Reset mid-operation: all in-flight and queued results are lost. After rst deasserts, the first grant goes to the lowest valid channel.

Test Plan:
- Single channel 0, op=1, a=8'hFF, b=8'h01, FIFO empty, out_ready=1 -> in_ready[0]=1 same cycle; next cycle out_valid=1, out_ch=0, out_result=16'h0100.
- All 4 channels valid continuously, out_ready=1 -> grants cycle 0,1,2,3,0; out_ch sequence matches; no channel starved.
- out_ready=0, channel 2 streams op=4 a=8'd15 b=8'd17 -> 8 transfers, then in_ready=0. out_result stays 16'd255 at head. Raising out_ready with valid held gives one pop and one push per cycle at full.
- Channel 1 sends op=0 then op=6 -> neither appears at output; drop_cnt=1; rr_ptr advances to 2 after each transfer.
- Queue 5 results, pulse alu_rst for 1 cycle with out_ready=1 -> out_valid=0 next cycle, in_ready=0 during the pulse, drop_cnt unchanged, next grant goes to lowest valid channel.
- Assert rst low asynchronously mid-stream, between clock edges -> in_ready and out_valid drop to 0 immediately, drop_cnt=0; normal operation resumes after release.

Source files
------------

// File: rtl/alu_in_mc_frontend_if.sv
// Bundle of the multi-channel alu_in request side and the single result port.
// The environment (requesters + result consumer) drives the master view; the
// frontend uses the slave view.
interface alu_in_mc_if #(
    parameter int NUM_CH          = 4,
    parameter int ALU_IN_OP_WIDTH = 8,
    parameter int CH_W            = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]                 in_valid;
    logic [NUM_CH-1:0]                 in_ready;
    logic [3*NUM_CH-1:0]               in_op;
    logic [ALU_IN_OP_WIDTH*NUM_CH-1:0] in_a;
    logic [ALU_IN_OP_WIDTH*NUM_CH-1:0] in_b;
    logic                              out_valid;
    logic                              out_ready;
    logic [CH_W-1:0]                   out_ch;
    logic [2:0]                        out_op;
    logic [2*ALU_IN_OP_WIDTH-1:0]      out_result;
    logic [7:0]                        drop_cnt;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_ch, out_op, out_result, drop_cnt
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_ch, out_op, out_result, drop_cnt
    );
endinterface

// File: rtl/alu_in_mc_frontend.sv
// Multi-channel alu_in frontend: round-robin arbitration over NUM_CH request
// channels, combinational ALU evaluation of the granted request, and a
// DEPTH-entry result FIFO tagged with channel and opcode.
module alu_in_mc_frontend #(
    parameter int NUM_CH          = 4,
    parameter int ALU_IN_OP_WIDTH = 8,
    parameter int DEPTH           = 8
) (
    input  logic        clk,
    input  logic        rst,      // asynchronous, active-low
    input  logic        alu_rst,  // synchronous flush, active-high
    alu_in_mc_if.slave  bus
);
    localparam int W     = ALU_IN_OP_WIDTH;
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RES_W = 2 * W;
    localparam int ENT_W = CH_W + 3 + RES_W;

    // Drop counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Full-width unsigned result; nothing is truncated or saturated.
    function automatic logic [RES_W-1:0] alu_eval(input logic [2:0]   op,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [RES_W-1:0] r;
        r = '0;
        case (op)
            3'd1:    r = {{W{1'b0}}, a} + {{W{1'b0}}, b};
            3'd2:    r = {{W{1'b0}}, a & b};
            3'd3:    r = {{W{1'b0}}, a ^ b};
            3'd4:    r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Only real ALU operations produce a result; no_op and reserved are consumed silently.
    function automatic logic op_enqueues(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    logic [2:0]        sel_op;
    logic [W-1:0]      sel_a;
    logic [W-1:0]      sel_b;
    logic              space;
    logic              xfer;
    logic              push;
    logic              pop;
    logic              out_valid_c;
    logic [NUM_CH-1:0] in_ready_c;
    logic              wr_en_d;
    logic [ENT_W-1:0]  wr_data_d;
    logic [ENT_W-1:0]  head;

    // Round-robin search: first valid channel at or after rr_ptr, wrapping.
    always_comb begin
        int sum;
        logic [CH_W-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            idx = CH_W'(sum);
            if (!gnt_found && bus.in_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Select the granted request, decide accept/push/pop and build the FIFO entry.
    always_comb begin
        sel_op      = bus.in_op[3*int'(gnt_idx) +: 3];
        sel_a       = bus.in_a[W*int'(gnt_idx) +: W];
        sel_b       = bus.in_b[W*int'(gnt_idx) +: W];
        out_valid_c = (count_q != '0);
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        space       = (count_q < CNT_W'(DEPTH)) || (out_valid_c && bus.out_ready);
        // rst is folded in so in_ready drops the moment reset asserts.
        xfer        = rst && !alu_rst && space && gnt_found;
        in_ready_c  = '0;
        if (xfer) in_ready_c[gnt_idx] = 1'b1;
        pop         = out_valid_c && bus.out_ready && !alu_rst;
        push        = xfer && op_enqueues(sel_op);
        wr_en_d     = push;
        wr_data_d   = {gnt_idx, sel_op, alu_eval(sel_op, sel_a, sel_b)};
    end

    // Next-state for pointers, occupancy, arbitration pointer and drop counter.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rr_ptr_d   = rr_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (alu_rst) begin
            // Flush discards queued results but keeps the drop statistics.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            rr_ptr_d = '0;
        end else begin
            if (xfer) begin
                rr_ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
                if (sel_op >= 3'd5) drop_cnt_d = sat_inc8(drop_cnt_q);
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Result storage; contents are only meaningful where count says so, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_d) mem_q[wr_ptr_q] <= wr_data_d;
    end

    // Present the FIFO head, forced to zero while the FIFO is empty.
    always_comb begin
        head = out_valid_c ? mem_q[rd_ptr_q] : '0;
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_ch     = head[ENT_W-1 -: CH_W];
    assign bus.out_op     = head[RES_W +: 3];
    assign bus.out_result = head[RES_W-1:0];
    assign bus.drop_cnt   = drop_cnt_q;
endmodule
